// File: rtl/counter_checker_if.sv
// counter_checker_if: observed counter bus plus checker status outputs
interface counter_checker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             mon_rst;
    logic             mon_en;
    logic [WIDTH-1:0] mon_out;
    logic             err_pulse;
    logic             err_flag;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] wrap_count;
    logic             pass;
    logic [3:0]       leds;
    modport master (
        output mon_rst, mon_en, mon_out,
        input  err_pulse, err_flag, err_count, wrap_count, pass, leds
    );
    modport slave (
        input  mon_rst, mon_en, mon_out,
        output err_pulse, err_flag, err_count, wrap_count, pass, leds
    );
endinterface

// File: rtl/counter_checker.sv
// counter_checker: predicts an observed enable counter every cycle and reports mismatches/progress
module counter_checker #(
    parameter int          WIDTH       = 4,
    parameter int          CNT_W       = 8,
    parameter int unsigned PASS_WRAPS  = 2,
    parameter bit          STOP_ON_ERR = 1'b1
) (
    input logic         clk,
    input logic         rst,
    counter_checker_if.slave bus
);
    typedef enum logic [1:0] {SYNC = 2'b00, CHECK = 2'b01, FAIL = 2'b10} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d, pred_exp, pred_obs;
    logic             err_pulse_q, err_pulse_d;
    logic             err_flag_q, err_flag_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] wrap_count_q, wrap_count_d;
    logic             pass_q, pass_d;
    assign pred_exp = bus.mon_rst ? '0 : bus.mon_en ? exp_q + 1'b1 : exp_q;
    assign pred_obs = bus.mon_rst ? '0 : bus.mon_en ? bus.mon_out + 1'b1 : bus.mon_out;
    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        err_pulse_d  = 1'b0;
        err_flag_d   = err_flag_q;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;
        case (state_q)
            SYNC: begin
                exp_d   = pred_obs;
                state_d = CHECK;
            end
            CHECK: begin
                if (bus.mon_out == exp_q) begin
                    exp_d = pred_exp;
                    // a wrap only counts when the checked value actually rolls over
                    if (!bus.mon_rst && bus.mon_en && &exp_q)
                        wrap_count_d = &wrap_count_q ? wrap_count_q : wrap_count_q + 1'b1;
                end else begin
                    err_pulse_d = 1'b1;
                    err_flag_d  = 1'b1;
                    err_count_d = &err_count_q ? err_count_q : err_count_q + 1'b1;
                    state_d     = STOP_ON_ERR ? FAIL : CHECK;
                    exp_d       = STOP_ON_ERR ? exp_q : pred_obs;
                end
            end
            FAIL: ;
            default: state_d = SYNC;
        endcase
        pass_d = (32'(wrap_count_d) >= PASS_WRAPS) && !err_flag_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SYNC;
            exp_q        <= '0;
            err_pulse_q  <= 1'b0;
            err_flag_q   <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            err_pulse_q  <= err_pulse_d;
            err_flag_q   <= err_flag_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
            pass_q       <= pass_d;
        end
    end
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_flag   = err_flag_q;
    assign bus.err_count  = err_count_q;
    assign bus.wrap_count = wrap_count_q;
    assign bus.pass       = pass_q;
    assign bus.leds       = {err_flag_q, pass_q, state_q};
endmodule
